// File: rtl/mem_port.sv
// Multicycle-CPU memory port: arbitrates fetch/read/write requests into a held memory handshake.
// Define MEM_TIMEOUT_EN to add the REQ-state watchdog (limit TMO) and the sticky err flag.
module mem_port #(
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          IRWrite,
    input  logic          IorD,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] alu_addr,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] instr_out,
    output logic [DW-1:0] mdr_out,
    output logic          stall,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} kind_t;

    state_t state;
    kind_t  kind;
    logic   any_req;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = TMO[7:0];
    logic [7:0] cnt;
`endif

    assign any_req = MemRead | MemWrite | IRWrite;

    // Gated by reset so the controller is never held while the port is being cleared.
    assign stall = reset && ((state == REQ) || ((state == IDLE) && any_req));

`ifndef MEM_TIMEOUT_EN
    assign err = 1'b0;
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // updates from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            kind      <= K_FETCH;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            instr_out <= '0;
            mdr_out   <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt       <= '0;
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_addr  <= IorD ? alu_addr : pc_in;
                        mem_wdata <= wdata;
                        mem_we    <= MemWrite;
                        // Lower-priority requests are simply dropped.
                        kind      <= MemWrite ? K_WRITE : (MemRead ? K_READ : K_FETCH);
`ifdef MEM_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        case (kind)
                            K_FETCH: instr_out <= mem_rdata;
                            K_READ:  mdr_out   <= mem_rdata;
                            default: ;
                        endcase
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt + 8'd1 == TMO_LIMIT) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        cnt     <= cnt + 8'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Scoreboard bench for mem_port: stimulus pushes expected requests/results, a negedge monitor pops and compares.
// Also covers the MEM_TIMEOUT_EN build when that macro is defined (TMO overridden to 4).
module tb_mem_port;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemRead, MemWrite, IRWrite, IorD;
    logic [DW-1:0] pc_in, alu_addr, wdata, mem_rdata;
    logic          mem_ack;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata, instr_out, mdr_out;
    logic          stall, err;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] mdr;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];

    logic [DW-1:0] exp_instr, exp_mdr;

    mem_port #(.DW(DW), .TMO(4)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .IorD(IorD),
        .pc_in(pc_in), .alu_addr(alu_addr), .wdata(wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .instr_out(instr_out), .mdr_out(mdr_out), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] data);
        req_t r;
        r.we = we; r.addr = addr; r.data = data;
        req_q.push_back(r);
    endtask

    task automatic push_res();
        res_t r;
        r.instr = exp_instr; r.mdr = exp_mdr;
        res_q.push_back(r);
    endtask

    // Monitor: checks request fields for every REQ cycle and register contents after each accepted ack.
    initial begin
        bit   prev_req;
        bit   ack_seen;
        req_t cur;
        res_t r;
        prev_req = 1'b0;
        ack_seen = 1'b0;
        cur.we = 1'b0; cur.addr = '0; cur.data = '0;
        forever begin
            @(negedge clk);
            if (ack_seen) begin
                ack_seen = 1'b0;
                if (res_q.size() == 0) begin
                    tests++; failed++;
                    $display("FAIL unexpected_result: got instr 0x%08h, expected no load", instr_out);
                end else begin
                    r = res_q.pop_front();
                    check("mon_instr_out", instr_out, r.instr);
                    check("mon_mdr_out", mdr_out, r.mdr);
                end
            end
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    tests++; failed++;
                    $display("FAIL unexpected_request: got addr 0x%08h, expected no request", mem_addr);
                end else begin
                    cur = req_q.pop_front();
                end
            end
            if (mem_req) begin
                check("mon_mem_addr", mem_addr, cur.addr);
                check("mon_mem_wdata", mem_wdata, cur.data);
                check("mon_mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                if (mem_ack) ack_seen = 1'b1;
            end
            prev_req = mem_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        exp_instr = '0;
        exp_mdr   = '0;
        reset = 1'b0;
        MemRead = 1'b1; MemWrite = 1'b0; IRWrite = 1'b1; IorD = 1'b0;
        pc_in = 32'h4; alu_addr = 32'h8; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        #1;
        check("stall_in_reset", {31'd0, stall}, 32'd0);
        tick(); tick();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_mdr_out", mdr_out, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        MemRead = 1'b0; IRWrite = 1'b0;
        reset = 1'b1;
        tick();
        check("idle_stall", {31'd0, stall}, 32'd0);

        // Fetch from pc_in, ack on the first REQ cycle.
        IRWrite = 1'b1; IorD = 1'b0; pc_in = 32'h10; wdata = 32'h0;
        push_req(1'b0, 32'h10, 32'h0);
        #1;
        check("fetch_stall_idle", {31'd0, stall}, 32'd1);
        tick();
        IRWrite = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5C000007;
        exp_instr = 32'h5C000007; push_res();
        check("fetch_stall_req", {31'd0, stall}, 32'd1);
        check("fetch_mem_req", {31'd0, mem_req}, 32'd1);
        tick();
        mem_ack = 1'b0;
        check("fetch_stall_done", {31'd0, stall}, 32'd0);
        check("fetch_instr", instr_out, 32'h5C000007);
        tick();

        // Store via alu_addr; inputs change during REQ to prove the latched values hold.
        MemWrite = 1'b1; IorD = 1'b1; alu_addr = 32'h40; wdata = 32'hDEADBEEF;
        push_req(1'b1, 32'h40, 32'hDEADBEEF);
        tick();
        MemWrite = 1'b0; alu_addr = 32'h1234; wdata = 32'h0BADF00D; mem_rdata = 32'hFFFFFFFF;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req) n++;
            tick();
        end
        mem_ack = 1'b1;
        if (mem_req) n++;
        push_res();
        tick();
        mem_ack = 1'b0;
        check("store_req_cycles", n, 32'd4);
        check("store_instr_kept", instr_out, exp_instr);
        check("store_mdr_kept", mdr_out, exp_mdr);
        tick();

        // All three requests at once: only the write is issued.
        MemRead = 1'b1; MemWrite = 1'b1; IRWrite = 1'b1; IorD = 1'b0;
        pc_in = 32'h20; wdata = 32'h12345678;
        push_req(1'b1, 32'h20, 32'h12345678);
        tick();
        MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
        check("prio_we", {31'd0, mem_we}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
        push_res();
        tick();
        mem_ack = 1'b0;
        tick();
        check("prio_no_second", {31'd0, mem_req}, 32'd0);
        check("prio_mdr_kept", mdr_out, 32'd0);

        // Read into MDR; ack held through DONE and into IDLE with new data must be ignored.
        MemRead = 1'b1; IorD = 1'b1; alu_addr = 32'h44;
        push_req(1'b0, 32'h44, 32'h12345678);
        tick();
        MemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        exp_mdr = 32'hCAFEF00D; push_res();
        tick();
        mem_rdata = 32'hBAD0BAD0;
        tick();
        check("ack_done_ignored", mdr_out, 32'hCAFEF00D);
        tick();
        mem_ack = 1'b0;
        check("ack_idle_ignored", mdr_out, 32'hCAFEF00D);
        check("ack_idle_instr", instr_out, exp_instr);

        // Back-to-back: IRWrite held; ignored in DONE, new transaction from IDLE.
        IRWrite = 1'b1; IorD = 1'b0; pc_in = 32'h30;
        push_req(1'b0, 32'h30, 32'h12345678);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        exp_instr = 32'h11111111; push_res();
        tick();
        mem_ack = 1'b0;
        check("b2b_done_stall", {31'd0, stall}, 32'd0);
        check("b2b_done_req", {31'd0, mem_req}, 32'd0);
        push_req(1'b0, 32'h30, 32'h12345678);
        tick();
        check("b2b_idle_req", {31'd0, mem_req}, 32'd0);
        check("b2b_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        check("b2b_second_req", {31'd0, mem_req}, 32'd1);
        IRWrite = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h22222222;
        exp_instr = 32'h22222222; push_res();
        tick();
        mem_ack = 1'b0;
        tick();

        // Reset in REQ abandons the access; a later ack loads nothing.
        IRWrite = 1'b1; pc_in = 32'h50;
        push_req(1'b0, 32'h50, 32'h12345678);
        tick();
        IRWrite = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        tick();
        reset = 1'b1;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_we", {31'd0, mem_we}, 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        check("rst_mid_wdata", mem_wdata, 32'd0);
        check("rst_mid_instr", instr_out, 32'd0);
        check("rst_mid_mdr", mdr_out, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        tick();
        mem_ack = 1'b0;
        check("rst_late_ack_instr", instr_out, 32'd0);
        check("rst_late_ack_req", {31'd0, mem_req}, 32'd0);
        exp_instr = '0; exp_mdr = '0;
        tick();

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no ack, back to IDLE after 4 REQ cycles with sticky err.
        IRWrite = 1'b1; pc_in = 32'h60;
        push_req(1'b0, 32'h60, 32'h12345678);
        tick();
        IRWrite = 1'b0;
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            tick();
        end
        check("tmo_req_cycles", n, 32'd4);
        check("tmo_err", {31'd0, err}, 32'd1);
        check("tmo_no_load", instr_out, 32'd0);
        IRWrite = 1'b1; pc_in = 32'h64;
        push_req(1'b0, 32'h64, 32'h12345678);
        tick();
        IRWrite = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h33333333;
        exp_instr = 32'h33333333; push_res();
        tick();
        mem_ack = 1'b0;
        check("tmo_err_sticky", {31'd0, err}, 32'd1);
        check("tmo_fetch_after", instr_out, 32'h33333333);
`else
        // Without the watchdog, REQ waits indefinitely and err stays 0.
        IRWrite = 1'b1; pc_in = 32'h70;
        push_req(1'b0, 32'h70, 32'h12345678);
        tick();
        IRWrite = 1'b0;
        repeat (300) tick();
        check("wait_req_held", {31'd0, mem_req}, 32'd1);
        check("wait_err", {31'd0, err}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        exp_instr = 32'h77777777; push_res();
        tick();
        mem_ack = 1'b0;
        check("wait_fetch", instr_out, 32'h77777777);
`endif
        tick(); tick();
        check("req_queue_empty", req_q.size(), 32'd0);
        check("res_queue_empty", res_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 Parameter DW, default 32, data and address width in bits.
REQ-002 Parameter TMO, default 255, watchdog limit in REQ-state cycles; used only with MEM_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-low.
REQ-005 MemRead  in  1  controller data-read request.
REQ-006 MemWrite  in  1  controller data-write request.
REQ-007 IRWrite  in  1  controller instruction-fetch request.
REQ-008 IorD  in  1  address select: 0 = pc_in, 1 = alu_addr.
REQ-009 pc_in  in  DW  current PC, word address.
REQ-010 alu_addr  in  DW  ALU register output, word address.
REQ-011 wdata  in  DW  store data (regB).
REQ-012 mem_rdata  in  DW  memory read data, valid when mem_ack=1.
REQ-013 mem_ack  in  1  memory completion strobe, one cycle.
REQ-014 mem_req  out  1  memory request, held until ack.
REQ-015 mem_we  out  1  write qualifier for mem_req.
REQ-016 mem_addr  out  DW  registered request address.
REQ-017 mem_wdata  out  DW  registered store data.
REQ-018 instr_out  out  DW  instruction register, feeds controller instr_in.
REQ-019 mdr_out  out  DW  memory data register, feeds write-back mux.
REQ-020 stall  out  1  controller hold; combinational.
REQ-021 err  out  1  sticky timeout flag.

Function
REQ-022 FSM states IDLE, REQ, DONE; IDLE->REQ on any request, REQ->DONE on mem_ack, DONE->IDLE unconditionally.
REQ-023 Requests are sampled only in IDLE; requests in REQ or DONE are ignored.
REQ-024 Priority on simultaneous requests: MemWrite > MemRead > IRWrite; lower-priority requests are dropped, not queued.
REQ-025 On IDLE->REQ, mem_addr latches pc_in if IorD=0, else alu_addr; mem_wdata latches wdata; mem_we latches 1 for a write, else 0; request kind is latched internally.
REQ-026 mem_req = 1 exactly while in REQ; mem_addr, mem_wdata and mem_we stay stable throughout REQ.
REQ-027 On the ack edge, a fetch loads mem_rdata into instr_out and a read loads it into mdr_out; a write loads neither.
REQ-028 instr_out and mdr_out hold their values at all other times.
REQ-029 stall = (state==REQ) OR (state==IDLE AND any request); stall = 0 in DONE.
REQ-030 Minimum latency: request at edge N, mem_req at N+1, ack sampled at N+1, result visible and stall low at N+2.
REQ-031 Ack while in IDLE or DONE is ignored.

Reset
REQ-032 reset=0 at an edge forces state IDLE and sets mem_req, mem_we, mem_addr, mem_wdata, instr_out, mdr_out, err and the watchdog counter to 0.
REQ-033 Reset mid-transaction abandons the access; mem_req is 0 from the next cycle, and a later ack is ignored.
REQ-034 stall is 0 during reset regardless of the request inputs.

Configuration
REQ-035 With MEM_TIMEOUT_EN defined, an 8-bit counter clears on IDLE->REQ and increments each REQ cycle without ack; when it reaches TMO, the FSM goes to IDLE, mem_req drops, err sets (sticky until reset), and neither register is loaded.
REQ-036 Without MEM_TIMEOUT_EN, the counter is absent, REQ waits indefinitely, and err is tied to 0.

Verification
REQ-037 Fetch: IRWrite=1, IorD=0, pc_in=0x10, ack the next cycle with rdata=0x5C000007 -> mem_addr=0x10, mem_we=0, instr_out=0x5C000007 at N+2, stall high for 2 cycles.
REQ-038 Store: MemWrite=1, IorD=1, alu_addr=0x40, wdata=0xDEADBEEF, ack after 3 cycles -> mem_we=1, addr and data stable for 4 REQ cycles, instr_out and mdr_out unchanged.
REQ-039 Simultaneous MemRead+MemWrite+IRWrite -> a single write transaction with mem_we=1 and no read.
REQ-040 Reset asserted during REQ, then ack pulsed after release -> mem_req=0, all registers 0, no register load.
REQ-041 MEM_TIMEOUT_EN, TMO=4, ack never asserted -> IDLE after 4 REQ cycles, err=1, err stays 1 after a later successful fetch.
REQ-042 Back-to-back: second request asserted during DONE is ignored; the same request held into IDLE starts a new transaction one cycle later.
